// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchroniser, oversampled 2-of-3 majority bit decisions,
// 5..8 data bits with optional parity and 1/2 stop bits, break detection, show-ahead RX FIFO with RTS.
module uart_rx_cfg #(
   parameter int SystemClockFreq = 50_000_000,
   parameter int OverSample      = 16,
   parameter int FifoDepth       = 8,
   parameter int RtsMargin       = 2
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_enable,
   input  logic [15:0]                  i_baud_div,
   input  logic [1:0]                   i_data_len,
   input  logic [1:0]                   i_parity_mode,
   input  logic                         i_stop_bits,
   input  logic                         i_rx,
   input  logic                         i_rx_req,
   input  logic                         i_ovr_clr,
   output logic [7:0]                   o_rx_data,
   output logic [2:0]                   o_rx_status,
   output logic                         o_rx_rdy,
   output logic [$clog2(FifoDepth):0]   o_fifo_count,
   output logic                         o_overrun,
   output logic                         o_rts
);

   localparam int PtrW = $clog2(FifoDepth);
   localparam int CntW = PtrW + 1;
   localparam int SampW = $clog2(OverSample);
   localparam logic [SampW-1:0] SampLo   = SampW'(OverSample / 2 - 1);
   localparam logic [SampW-1:0] SampMid  = SampW'(OverSample / 2);
   localparam logic [SampW-1:0] SampHi   = SampW'(OverSample / 2 + 1);
   localparam logic [SampW-1:0] SampLast = SampW'(OverSample - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FifoDepth);
   localparam logic [CntW-1:0]  CntRts   = CntW'(FifoDepth - RtsMargin);

   if (SystemClockFreq <= 0 || OverSample < 8 || (OverSample % 2) != 0 || FifoDepth < 4 ||
       (FifoDepth & (FifoDepth - 1)) != 0 || RtsMargin >= FifoDepth) begin : g_param_check
      $error("uart_rx_cfg: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT
   } state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_bit(input logic [7:0] d, input logic odd);
      return odd ? ~^d : ^d;
   endfunction

   // Line synchroniser; rx_prev feeds the falling-edge detector
   logic rx_sync_p0, rx_sync_p1, rx_prev;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
         rx_prev    <= 1'b1;
      end else begin
         rx_sync_p0 <= i_rx;
         rx_sync_p1 <= rx_sync_p0;
         rx_prev    <= rx_sync_p1;
      end
   end

   state_t           state_q, state_d;
   logic [15:0]      tick_cnt;
   logic [SampW-1:0] samp_cnt;
   logic [2:0]       bit_idx;
   logic             tick, start_edge, decide, bit_end, maj;
   logic             smp_a, smp_b;
   logic [2:0]       len_q;
   logic             par_en_q, par_odd_q, stop2_q;
   logic [7:0]       data_sr;
   logic             par_err_q, frm_err_q, all_zero_q;
   logic             push, is_brk, frame_bad;
   logic [7:0]       push_data;
   logic [2:0]       push_stat;

   assign tick       = (tick_cnt >= i_baud_div);
   assign start_edge = (state_q == IDLE) && i_enable && rx_prev && !rx_sync_p1;
   assign decide     = tick && (samp_cnt == SampHi);
   assign bit_end    = tick && (samp_cnt == SampLast);
   assign maj        = maj3(smp_a, smp_b, rx_sync_p1);
   assign frame_bad  = frm_err_q | ~maj;
   assign is_brk     = all_zero_q & ~maj;
   assign push_data  = is_brk ? 8'h00 : data_sr;
   assign push_stat  = is_brk ? 3'b110 : {1'b0, frame_bad, par_err_q};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         tick_cnt <= '0;
         samp_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         state_q <= state_d;
         if (start_edge || tick) tick_cnt <= '0;
         else                    tick_cnt <= tick_cnt + 16'd1;
         if (start_edge)
            samp_cnt <= '0;
         else if (tick && state_q != IDLE)
            samp_cnt <= (samp_cnt == SampLast) ? '0 : samp_cnt + SampW'(1);
         if (start_edge)
            bit_idx <= '0;
         else if (state_q == DATA && bit_end)
            bit_idx <= bit_idx + 3'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         IDLE:     if (start_edge) state_d = START;
         START: begin
            if (decide && maj) state_d = IDLE;
            else if (bit_end)  state_d = DATA;
         end
         DATA:     if (bit_end && bit_idx == len_q) state_d = par_en_q ? PARITY : STOP1;
         PARITY:   if (bit_end) state_d = STOP1;
         STOP1: begin
            if (decide && !stop2_q) begin
               push    = 1'b1;
               state_d = frame_bad ? BRK_WAIT : IDLE;
            end else if (bit_end && stop2_q) begin
               state_d = STOP2;
            end
         end
         STOP2: begin
            if (decide) begin
               push    = 1'b1;
               state_d = frame_bad ? BRK_WAIT : IDLE;
            end
         end
         BRK_WAIT: if (rx_sync_p1) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
      // Disabling the receiver drops whatever frame is in flight
      if (!i_enable && state_q != IDLE) begin
         state_d = IDLE;
         push    = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (start_edge) begin
         len_q      <= {1'b1, i_data_len};
         par_en_q   <= (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
         par_odd_q  <= (i_parity_mode == 2'b10);
         stop2_q    <= i_stop_bits;
         data_sr    <= '0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         all_zero_q <= 1'b1;
      end else if (decide) begin
         case (state_q)
            DATA: begin
               data_sr[bit_idx] <= maj;
               all_zero_q       <= all_zero_q & ~maj;
            end
            PARITY: begin
               par_err_q  <= (maj != parity_bit(data_sr, par_odd_q));
               all_zero_q <= all_zero_q & ~maj;
            end
            STOP1: begin
               frm_err_q  <= frm_err_q | ~maj;
               all_zero_q <= all_zero_q & ~maj;
            end
            default: ;
         endcase
      end
      if (tick && samp_cnt == SampLo)  smp_a <= rx_sync_p1;
      if (tick && samp_cnt == SampMid) smp_b <= rx_sync_p1;
   end

   // Show-ahead FIFO: head is visible combinationally whenever non-empty
   logic [7:0]      mem_data [FifoDepth];
   logic [2:0]      mem_stat [FifoDepth];
   logic [PtrW-1:0] wr_ptr, rd_ptr;
   logic [CntW-1:0] count, count_d;
   logic            full, empty, pop, wr_en, ovr_set;
   logic            overrun_q, rts_q;

   assign full    = (count == CntFull);
   assign empty   = (count == '0);
   assign pop     = i_rx_req && !empty;
   assign wr_en   = push && (!full || pop);
   assign ovr_set = push && full && !pop;

   always_comb begin
      count_d = count;
      case ({wr_en, pop})
         2'b10:   count_d = count + CntW'(1);
         2'b01:   count_d = count - CntW'(1);
         default: count_d = count;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun_q <= 1'b0;
         rts_q     <= 1'b1;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop)   rd_ptr <= rd_ptr + PtrW'(1);
         count <= count_d;
         if (ovr_set)        overrun_q <= 1'b1;
         else if (i_ovr_clr) overrun_q <= 1'b0;
         rts_q <= (count_d < CntRts);
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_data[wr_ptr] <= push_data;
         mem_stat[wr_ptr] <= push_stat;
      end
   end

   assign o_rx_data    = empty ? 8'h00 : mem_data[rd_ptr];
   assign o_rx_status  = empty ? 3'b000 : mem_stat[rd_ptr];
   assign o_rx_rdy     = !empty;
   assign o_fifo_count = count;
   assign o_overrun    = overrun_q;
   assign o_rts        = rts_q;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL use a single clock `i_clk`; reset `i_rst_n` SHALL be synchronous and active-low.
REQ-002 Parameters (name, default, meaning):
- SystemClockFreq, 50_000_000, clock frequency in Hz (documentation only).
- OverSample, 16, oversample ticks per bit; even, >=8.
- FifoDepth, 8, RX FIFO entries; power of two, >=4.
- RtsMargin, 2, free-entry threshold for deasserting RTS; <FifoDepth.
REQ-003 Ports (name, direction, width, meaning):
- i_clk, in, 1, system clock.
- i_rst_n, in, 1, sync active-low reset.
- i_enable, in, 1, receiver enable.
- i_baud_div, in, 16, cycles per oversample tick minus 1.
- i_data_len, in, 2, data bits: 00=5, 01=6, 10=7, 11=8.
- i_parity_mode, in, 2, 00=none, 01=even, 10=odd, 11=none.
- i_stop_bits, in, 1, 0=one stop bit, 1=two stop bits.
- i_rx, in, 1, async serial line, idle high.
- i_rx_req, in, 1, pop FIFO head.
- i_ovr_clr, in, 1, clear sticky overrun.
- o_rx_data, out, 8, FIFO head data, LSB-first assembled, unused MSBs 0.
- o_rx_status, out, 3, FIFO head {break, frame, parity}.
- o_rx_rdy, out, 1, FIFO non-empty.
- o_fifo_count, out, $clog2(FifoDepth)+1, occupancy.
- o_overrun, out, 1, sticky overrun flag.
- o_rts, out, 1, 1 = peer may send.

Function
REQ-004 i_rx SHALL pass through a 2-flop synchroniser whose flops reset to 1; all sampling SHALL use the synchronised value.
REQ-005 Tick generator: counter SHALL run 0..i_baud_div and emit a 1-cycle tick on reaching i_baud_div; it SHALL reload to 0 on start-edge detection.
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
REQ-007 IDLE->START on a synchronised 1->0 transition while i_enable=1; i_data_len, i_parity_mode and i_stop_bits SHALL be latched at this transition and held for the frame.
REQ-008 Each bit SHALL be decided by 2-of-3 majority of samples at ticks OverSample/2-1, OverSample/2 and OverSample/2+1 within the bit.
REQ-009 START: majority 1 -> IDLE (false start, no push); majority 0 -> DATA.
REQ-010 DATA -> PARITY after the latched bit count when parity is enabled, else -> STOP1.
REQ-011 Parity error SHALL be flagged when the received parity bit differs from the even-mode value ^data (even) or ~^data (odd).
REQ-012 STOP1 -> STOP2 when i_stop_bits=1, else frame end; a stop bit sampled 0 SHALL set frame error.
REQ-013 Break condition: start, data, parity and all stop bits all 0.
- Push data=0 with status 3'b110; parity bit forced 0.
- Enter BRK_WAIT; BRK_WAIT -> IDLE only after the synchronised line reads 1.
REQ-014 Otherwise, frame end SHALL push {data, status} and return to IDLE on the cycle after the final stop decision; frame error SHALL also pass through BRK_WAIT.
REQ-015 FIFO SHALL be show-ahead: o_rx_data and o_rx_status reflect the head whenever o_rx_rdy=1.
REQ-016 i_rx_req with o_rx_rdy=1 SHALL pop at the clock edge; i_rx_req while empty SHALL be ignored.
REQ-017 Push while full without same-cycle pop:
- Frame dropped; o_overrun set.
- FIFO contents unchanged.
REQ-018 Push and pop in the same cycle SHALL both succeed, including when full; o_fifo_count is unchanged.
REQ-019 o_overrun SHALL stay set until an i_ovr_clr pulse. If set and clear coincide, set SHALL win.
REQ-020 o_rts SHALL be registered; o_rts=0 when o_fifo_count >= FifoDepth-RtsMargin, else 1.
REQ-021 i_enable deasserted mid-frame SHALL abort the frame to IDLE without a push; FIFO and flags SHALL be retained.

Reset
REQ-022 On i_rst_n=0 at a clock edge, the block SHALL reset to the following values:
- FSM=IDLE; FIFO empty.
- o_rx_rdy=0, o_fifo_count=0, o_overrun=0, o_rts=1.
- o_rx_data=0, o_rx_status=0.
- Tick counter=0; synchroniser=1.
REQ-023 Reset mid-frame SHALL discard the partial frame, and no push SHALL follow reset release.

Verification
REQ-024 Config 8E1, i_baud_div=26; send 0xA5 with parity 0 -> o_rx_rdy=1, o_rx_data=0xA5, o_rx_status=000.
REQ-025 Config 7O2; send 0x35 with a wrong parity bit -> o_rx_data=0x35, status=001. Repeat with the second stop bit 0 -> status=011.
REQ-026 Line held low for 2 frame times, then released -> exactly one entry, data=0x00, status=110; no further pushes until a new start edge.
REQ-027 FifoDepth=8; send 9 frames with no reads:
- o_rts=0 from count 6.
- o_fifo_count=8 and o_overrun=1.
- Pops return frames 1-8 in order.
- i_ovr_clr -> o_overrun=0.
REQ-028 Low glitch of OverSample/4 ticks on an idle line -> no push, FSM back in IDLE. Separately, reset asserted mid-DATA -> FIFO empty, no entry.
REQ-029 FIFO full, i_rx_req asserted on the push cycle -> count stays 8, o_overrun=0, new frame at tail.
